// File: rtl/tag_match_cam.sv
// Tag-match CAM: a small fully associative tag store with a registered lookup.
// A new tag goes into the lowest invalid entry. When every entry is valid, it
// replaces the entry at the round-robin victim pointer. A write whose tag is
// already stored is ignored. flush invalidates every entry. hit_cnt counts hits
// and saturates.
// Optional feature, enabled by defining TAG_MATCH_CAM_BYPASS_EN: a lookup that
// matches the tag being written in the same cycle reports a hit at the index
// that write allocates.

// WIDTH-bit equality comparator used for each tag compare.
module equaln #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);
    // Plain bitwise equality.
    assign eq = (a == b);
endmodule

module tag_match_cam #(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned ENTRIES = 4,
    localparam int unsigned IW      = $clog2(ENTRIES),
    localparam int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_tag,
    input  logic             lk_valid,
    input  logic [WIDTH-1:0] lk_tag,
    output logic             hit_valid,
    output logic             hit,
    output logic [IW-1:0]    hit_idx,
    output logic             full,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]   tags [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [IW-1:0]      victim;

    logic [ENTRIES-1:0] lk_eq;
    logic [ENTRIES-1:0] lk_match;
    logic               lk_any;
    logic [IW-1:0]      lk_idx;
    logic               wr_dup;
    logic [IW-1:0]      alloc_idx;
    logic               wr_accept;
    logic               fwd_hit;
    logic               lk_hit;
    logic [IW-1:0]      lk_hit_idx;

    // One comparator per entry, qualified by that entry's valid bit.
    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_cmp
        equaln #(.WIDTH(WIDTH)) u_eq (
            .a  (tags[g]),
            .b  (lk_tag),
            .eq (lk_eq[g])
        );
        assign lk_match[g] = lk_eq[g] & valid[g];
    end

    // Priority-encode the lowest matching entry.
    always_comb begin
        lk_any = 1'b0;
        lk_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                lk_any = 1'b1;
                lk_idx = IW'(i);
            end
        end
    end

    // Detect duplicates, then choose the allocation slot: the lowest invalid entry, else the victim.
    always_comb begin
        wr_dup    = 1'b0;
        alloc_idx = victim;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == wr_tag)) begin
                wr_dup = 1'b1;
            end
            if (!valid[i]) begin
                alloc_idx = IW'(i);
            end
        end
    end

    assign full      = &valid;
    assign wr_accept = wr_en & ~flush & ~wr_dup;

`ifdef TAG_MATCH_CAM_BYPASS_EN
    logic fwd_eq;

    // Forward an accepted same-cycle write to the lookup.
    equaln #(.WIDTH(WIDTH)) u_fwd_eq (
        .a  (wr_tag),
        .b  (lk_tag),
        .eq (fwd_eq)
    );
    assign fwd_hit = wr_accept & fwd_eq;
`else
    assign fwd_hit = 1'b0;
`endif

    // Lookup result before it is registered. A stored match takes priority over forwarding.
    always_comb begin
        lk_hit     = lk_valid & (lk_any | fwd_hit);
        lk_hit_idx = '0;
        if (lk_valid && lk_any) begin
            lk_hit_idx = lk_idx;
        end else if (lk_valid && fwd_hit) begin
            lk_hit_idx = alloc_idx;
        end
    end

    // Register the lookup result and update the hit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            hit_cnt   <= '0;
        end else begin
            hit_valid <= lk_valid;
            hit       <= lk_hit;
            hit_idx   <= lk_hit_idx;
            if (lk_hit && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

    // Tag array update: flush beats write; the victim pointer advances only on a replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            victim <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tags[i] <= '0;
            end
        end else if (flush) begin
            valid  <= '0;
            victim <= '0;
        end else if (wr_accept) begin
            tags[alloc_idx]  <= wr_tag;
            valid[alloc_idx] <= 1'b1;
            if (&valid) begin
                victim <= victim + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tag_match_cam.sv
// Bench for tag_match_cam (WIDTH=8, ENTRIES=4). It runs directed scenarios and
// then random traffic. Every expected value comes from a reference model of the
// tag store kept in plain arrays.
module tb_tag_match_cam;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_tag = '0;
    logic         lk_valid = 1'b0;
    logic [W-1:0] lk_tag = '0;
    logic         hit_valid;
    logic         hit;
    logic [1:0]   hit_idx;
    logic         full;
    logic [7:0]   hit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit       m_valid [N];
    bit [7:0] m_tag   [N];
    int       m_victim = 0;
    int       m_cnt = 0;

    tag_match_cam #(.WIDTH(W), .ENTRIES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_tag    (wr_tag),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .hit_valid (hit_valid),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .full      (full),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_tag(input bit [7:0] t);
        for (int i = 0; i < int'(N); i++) begin
            if (m_valid[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < int'(N); i++) begin
            if (!m_valid[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Apply one cycle of stimulus, then compare every output with the model.
    task automatic step(input bit f, input bit w, input bit [7:0] wt,
                        input bit l, input bit [7:0] lt, input string tag);
        bit exp_hit;
        int exp_idx;
        int m;
        bit acc;
        int alloc;
        bit was_full;
        exp_hit  = 1'b0;
        exp_idx  = 0;
        m        = find_tag(lt);
        if (l && m >= 0) begin
            exp_hit = 1'b1;
            exp_idx = m;
        end
        acc      = w && !f && (find_tag(wt) < 0);
        was_full = model_full();
        alloc    = m_victim;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!m_valid[i]) alloc = i;
        end
`ifdef TAG_MATCH_CAM_BYPASS_EN
        if (l && !exp_hit && acc && lt == wt) begin
            exp_hit = 1'b1;
            exp_idx = alloc;
        end
`endif
        flush    = f;
        wr_en    = w;
        wr_tag   = wt;
        lk_valid = l;
        lk_tag   = lt;
        @(posedge clk);
        #1;
        if (f) begin
            for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
            m_victim = 0;
        end else if (acc) begin
            m_tag[alloc]   = wt;
            m_valid[alloc] = 1'b1;
            if (was_full) m_victim = (m_victim + 1) % int'(N);
        end
        if (exp_hit && m_cnt < 255) m_cnt++;
        check({tag, ".hit_valid"}, 32'(hit_valid), 32'(l));
        check({tag, ".hit"},       32'(hit),       32'(exp_hit));
        check({tag, ".hit_idx"},   32'(hit_idx),   32'(exp_idx));
        check({tag, ".full"},      32'(full),      32'(model_full()));
        check({tag, ".hit_cnt"},   32'(hit_cnt),   32'(m_cnt));
    endtask

    // Reset with other requests active in the same cycle; reset must override them.
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        flush    = 1'($urandom_range(0, 1));
        wr_en    = 1'b1;
        wr_tag   = 8'($urandom);
        lk_valid = 1'b1;
        lk_tag   = 8'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
        m_victim = 0;
        m_cnt    = 0;
        check({tag, ".hit_valid"}, 32'(hit_valid), 32'd0);
        check({tag, ".hit"},       32'(hit),       32'd0);
        check({tag, ".hit_idx"},   32'(hit_idx),   32'd0);
        check({tag, ".full"},      32'(full),      32'd0);
        check({tag, ".hit_cnt"},   32'(hit_cnt),   32'd0);
    endtask

    initial begin
        // Zeroed stored tags never hit after reset.
        do_reset("rst0");
        step(0, 0, 8'h00, 1, 8'h00, "lk00");
        check("r28_hit", 32'(hit), 32'd0);

        // Fill the array, then look up an entry.
        step(0, 1, 8'h11, 0, 8'h00, "w11");
        step(0, 1, 8'h22, 0, 8'h00, "w22");
        step(0, 1, 8'h33, 0, 8'h00, "w33");
        step(0, 1, 8'h44, 0, 8'h00, "w44");
        step(0, 0, 8'h00, 1, 8'h33, "lk33");
        check("r29_idx",  32'(hit_idx), 32'd2);
        check("r29_full", 32'(full),    32'd1);
        check("r29_cnt",  32'(hit_cnt), 32'd1);

        // Round-robin replacement once the array is full.
        step(0, 1, 8'h55, 0, 8'h00, "w55");
        step(0, 1, 8'h66, 0, 8'h00, "w66");
        step(0, 0, 8'h00, 1, 8'h11, "lk11");
        check("r30_miss11", 32'(hit), 32'd0);
        step(0, 0, 8'h00, 1, 8'h66, "lk66");
        check("r30_idx66", 32'(hit_idx), 32'd1);
        step(0, 1, 8'h22, 0, 8'h00, "w22b");
        step(0, 0, 8'h00, 1, 8'h22, "lk22");
        check("r30_idx22", 32'(hit_idx), 32'd2);

        // Duplicate suppression and the point at which full asserts.
        do_reset("rst1");
        step(0, 1, 8'h22, 0, 8'h00, "d22a");
        step(0, 1, 8'h22, 0, 8'h00, "d22b");
        step(0, 1, 8'h33, 0, 8'h00, "d33");
        step(0, 1, 8'h44, 0, 8'h00, "d44");
        check("r31_notfull", 32'(full), 32'd0);
        step(0, 1, 8'h55, 0, 8'h00, "d55");
        check("r31_full", 32'(full), 32'd1);

        // flush wins over the write; the same-cycle lookup sees pre-flush state.
        do_reset("rst2");
        step(0, 1, 8'h11, 0, 8'h00, "f11");
        step(1, 1, 8'h77, 1, 8'h11, "fwl");
        check("r32_hit", 32'(hit), 32'd1);
        step(0, 0, 8'h00, 1, 8'h11, "f_lk11");
        step(0, 0, 8'h00, 1, 8'h77, "f_lk77");
        check("r32_full", 32'(full), 32'd0);

        // Same-cycle write and lookup of one tag, then saturate the hit counter.
        do_reset("rst3");
        step(0, 1, 8'h9A, 1, 8'h9A, "byp");
`ifdef TAG_MATCH_CAM_BYPASS_EN
        check("r33_byp", 32'(hit), 32'd1);
`else
        check("r33_byp", 32'(hit), 32'd0);
`endif
        for (int k = 0; k < 300; k++) begin
            step(0, 0, 8'h00, 1, 8'h9A, "sat");
        end
        check("r33_sat", 32'(hit_cnt), 32'd255);

        // Random traffic over a small tag space so hits and duplicates are frequent.
        do_reset("rst4");
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rnd_rst");
            end else begin
                step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 7)), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
